// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory-access stage and its helpers:
//   bundle widths, the global stall vector layout, the stall level
//   encoding and the load-flag bundle.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 76;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_RF_WD = 38;
  localparam int HILO_WD      = 66;

  localparam int StallBus = 6;
  localparam int LoadBus  = 5;

  // Positions in the global stall vector that this stage looks at.
  localparam int STALL_MEM_IN = 3;
  localparam int STALL_WB_IN  = 4;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Load flags in the order execute packs them, lb in the MSB.
  typedef struct packed {
    logic lb;
    logic lbu;
    logic lh;
    logic lhu;
    logic lw;
  } load_flags_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_stage_load_align
//   Purely combinational alignment/extension of SRAM read data for
//   lb/lbu/lh/lhu/lw using little-endian byte lanes.
//
// Ports:
//   i_rdata      [31:0]  raw SRAM read word
//   i_sel        [3:0]   byte-lane select of the access
//   i_load       flags   {lb, lbu, lh, lhu, lw}
//   o_mem_result [31:0]  aligned, extended load value (0 when no load
//                        or when the lane select does not fit the size)
import mem_stage_pkg::*;

module mem_stage_load_align (
  input  logic [31:0] i_rdata,
  input  logic [3:0]  i_sel,
  input  load_flags_t i_load,
  output logic [31:0] o_mem_result
);

  logic [7:0]  w_byte;
  logic        w_byte_ok;
  logic [15:0] w_half;
  logic        w_half_ok;

  always_comb begin
    w_byte    = 8'h00;
    w_byte_ok = 1'b1;
    unique case (i_sel)
      4'b0001: w_byte = i_rdata[7:0];
      4'b0010: w_byte = i_rdata[15:8];
      4'b0100: w_byte = i_rdata[23:16];
      4'b1000: w_byte = i_rdata[31:24];
      default: w_byte_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_half    = 16'h0000;
    w_half_ok = 1'b1;
    unique case (i_sel)
      4'b0011: w_half = i_rdata[15:0];
      4'b1100: w_half = i_rdata[31:16];
      default: w_half_ok = 1'b0;
    endcase
  end

  // Misaligned selects produce 0; trapping happens elsewhere.
  always_comb begin
    o_mem_result = 32'h0000_0000;
    if (i_load.lw) begin
      o_mem_result = i_rdata;
    end else if (i_load.lb && w_byte_ok) begin
      o_mem_result = {{24{w_byte[7]}}, w_byte};
    end else if (i_load.lbu && w_byte_ok) begin
      o_mem_result = {24'h000000, w_byte};
    end else if (i_load.lh && w_half_ok) begin
      o_mem_result = {{16{w_half[15]}}, w_half};
    end else if (i_load.lhu && w_half_ok) begin
      o_mem_result = {16'h0000, w_half};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access pipeline stage between execute and write-back.
//   Registers the execute bundle, load flags, byte-lane select and
//   HI/LO request under stall control, aligns the SRAM read data and
//   selects the register-file write value. All outputs are
//   combinational from the input register and the SRAM read data.
//
// Ports:
//   clk                 stage clock
//   rst                 asynchronous active-high reset
//   i_stall        [5:0]   global stall vector (bit 3 this stage, bit 4 next)
//   i_ex_to_mem_bus [75:0] {pc, data_ram_en, data_ram_wen, sel_rf_res,
//                           rf_we, rf_waddr, ex_result}
//   i_ex_load_bus  [4:0]   {lb, lbu, lh, lhu, lw}
//   i_ex_data_ram_sel [3:0] byte-lane select
//   i_ex_hilo_bus  [65:0]  {hi_we, lo_we, hi_wdata, lo_wdata}
//   i_data_sram_rdata [31:0] SRAM read data for the registered request
//   o_mem_to_wb_bus [69:0] {pc, rf_we, rf_waddr, rf_wdata}
//   o_mem_to_rf_bus [37:0] {rf_we, rf_waddr, rf_wdata} forwarding
//   o_mem_hilo_bus [65:0]  registered HI/LO request
import mem_stage_pkg::*;

module mem_stage (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     i_stall,
  input  logic [EX_TO_MEM_WD-1:0] i_ex_to_mem_bus,
  input  logic [LoadBus-1:0]      i_ex_load_bus,
  input  logic [3:0]              i_ex_data_ram_sel,
  input  logic [HILO_WD-1:0]      i_ex_hilo_bus,
  input  logic [31:0]             i_data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] o_mem_to_wb_bus,
  output logic [MEM_TO_RF_WD-1:0] o_mem_to_rf_bus,
  output logic [HILO_WD-1:0]      o_mem_hilo_bus
);

  logic [EX_TO_MEM_WD-1:0] r_ex_to_mem_bus;
  load_flags_t             r_load;
  logic [3:0]              r_sel;
  logic [HILO_WD-1:0]      r_hilo;

  logic w_bubble;
  logic w_capture;

  // Upstream stopped while downstream moves: insert an all-zero bubble
  // so a held load cannot commit its write twice.
  assign w_bubble  = (i_stall[STALL_MEM_IN] == Stop) && (i_stall[STALL_WB_IN] == NoStop);
  assign w_capture = (i_stall[STALL_MEM_IN] == NoStop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_to_mem_bus <= '0;
      r_load          <= '0;
      r_sel           <= '0;
      r_hilo          <= '0;
    end else if (w_bubble) begin
      r_ex_to_mem_bus <= '0;
      r_load          <= '0;
      r_sel           <= '0;
      r_hilo          <= '0;
    end else if (w_capture) begin
      r_ex_to_mem_bus <= i_ex_to_mem_bus;
      r_load          <= load_flags_t'(i_ex_load_bus);
      r_sel           <= i_ex_data_ram_sel;
      r_hilo          <= i_ex_hilo_bus;
    end
  end

  logic [31:0] w_pc;
  logic        w_sel_rf_res;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_ex_result;
  logic [31:0] w_mem_result;
  logic [31:0] w_rf_wdata;

  assign w_pc         = r_ex_to_mem_bus[75:44];
  assign w_sel_rf_res = r_ex_to_mem_bus[38];
  assign w_rf_we      = r_ex_to_mem_bus[37];
  assign w_rf_waddr   = r_ex_to_mem_bus[36:32];
  assign w_ex_result  = r_ex_to_mem_bus[31:0];

  mem_stage_load_align u_load_align (
    .i_rdata      (i_data_sram_rdata),
    .i_sel        (r_sel),
    .i_load       (r_load),
    .o_mem_result (w_mem_result)
  );

  assign w_rf_wdata = w_sel_rf_res ? w_mem_result : w_ex_result;

  assign o_mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
  assign o_mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};
  assign o_mem_hilo_bus  = r_hilo;

  // SRAM enable/write-enable were consumed by execute when issuing the
  // request; the other stall bits belong to other stages.
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, r_ex_to_mem_bus[43:39], i_stall[5], i_stall[2:0]};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [75:0] ex_bus;
  logic [4:0]  load_bus;
  logic [3:0]  ram_sel;
  logic [65:0] hilo_in;
  logic [31:0] rdata;
  logic [69:0] wb_bus;
  logic [37:0] rf_bus;
  logic [65:0] hilo_out;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] LD_LB  = 5'b10000;
  localparam logic [4:0] LD_LBU = 5'b01000;
  localparam logic [4:0] LD_LH  = 5'b00100;
  localparam logic [4:0] LD_LHU = 5'b00010;
  localparam logic [4:0] LD_LW  = 5'b00001;
  localparam logic [4:0] LD_NONE = 5'b00000;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .i_stall           (stall),
    .i_ex_to_mem_bus   (ex_bus),
    .i_ex_load_bus     (load_bus),
    .i_ex_data_ram_sel (ram_sel),
    .i_ex_hilo_bus     (hilo_in),
    .i_data_sram_rdata (rdata),
    .o_mem_to_wb_bus   (wb_bus),
    .o_mem_to_rf_bus   (rf_bus),
    .o_mem_hilo_bus    (hilo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [75:0] mk_ex(input logic [31:0] pc, input logic sel_rf_res,
                                        input logic we, input logic [4:0] waddr,
                                        input logic [31:0] result);
    mk_ex = {pc, 1'b1, 4'b0000, sel_rf_res, we, waddr, result};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load with stall released, present rdata in the following
  // cycle, and check the write-back value and full bus.
  task automatic do_load(input string tag, input logic [4:0] ld, input logic [3:0] sel,
                         input logic [31:0] rd, input logic [31:0] exp_wdata);
    ex_bus   = mk_ex(32'h0000_0100, 1'b1, 1'b1, 5'd5, 32'h0000_0055);
    load_bus = ld;
    ram_sel  = sel;
    stall    = 6'b000000;
    tick();
    rdata = rd;
    #1;
    check({tag, "_wdata"}, {38'h0, wb_bus[31:0]}, {38'h0, exp_wdata});
    check({tag, "_wb"}, wb_bus, {32'h0000_0100, 1'b1, 5'd5, exp_wdata});
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 6'b000000;
    ex_bus   = mk_ex(32'hBFC0_0000, 1'b0, 1'b1, 5'd3, 32'h1234_5678);
    load_bus = LD_LW;
    ram_sel  = 4'b1111;
    hilo_in  = {1'b1, 1'b1, 32'hAAAA_AAAA, 32'h5555_5555};
    rdata    = 32'hCAFE_F00D;

    // Outputs held at 0 under reset despite valid inputs and clock edges.
    #2;
    check("rst_wb", wb_bus, 70'h0);
    check("rst_rf", {32'h0, rf_bus}, 70'h0);
    check("rst_hilo", {4'h0, hilo_out}, 70'h0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_rel_wb", wb_bus, 70'h0);
    check("rst_rel_hilo", {4'h0, hilo_out}, 70'h0);

    do_load("lb_sign", LD_LB, 4'b0100, 32'h1280_3456, 32'hFFFF_FF80);
    do_load("lbu", LD_LBU, 4'b0100, 32'h1280_3456, 32'h0000_0080);
    do_load("lb_lane0", LD_LB, 4'b0001, 32'h0000_00FF, 32'hFFFF_FFFF);
    do_load("lbu_lane3", LD_LBU, 4'b1000, 32'hA512_3456, 32'h0000_00A5);
    do_load("lh", LD_LH, 4'b1100, 32'h9ABC_0001, 32'hFFFF_9ABC);
    do_load("lhu", LD_LHU, 4'b0011, 32'h1234_8765, 32'h0000_8765);
    do_load("lh_pos", LD_LH, 4'b0011, 32'hFFFF_7FFF, 32'h0000_7FFF);
    do_load("lw", LD_LW, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lh_misalign", LD_LH, 4'b0110, 32'hFFFF_FFFF, 32'h0000_0000);
    do_load("lb_badsel", LD_LB, 4'b0011, 32'hFFFF_FFFF, 32'h0000_0000);

    // Non-load pass-through, register 0 write passed unchanged.
    ex_bus   = mk_ex(32'h0000_0200, 1'b0, 1'b1, 5'd7, 32'h0000_002A);
    load_bus = LD_NONE;
    ram_sel  = 4'b0000;
    tick();
    rdata = 32'hFFFF_FFFF;
    #1;
    check("alu_wb", wb_bus, {32'h0000_0200, 1'b1, 5'd7, 32'h0000_002A});
    check("alu_rf", {32'h0, rf_bus}, {32'h0, 1'b1, 5'd7, 32'h0000_002A});
    ex_bus = mk_ex(32'h0000_0204, 1'b0, 1'b1, 5'd0, 32'h0000_0033);
    tick();
    check("waddr0_rf", {32'h0, rf_bus}, {32'h0, 1'b1, 5'd0, 32'h0000_0033});
    // Result-select with no load flag yields 0.
    ex_bus = mk_ex(32'h0000_0208, 1'b1, 1'b1, 5'd9, 32'h0000_0077);
    tick();
    check("noload_sel", {32'h0, rf_bus}, {32'h0, 1'b1, 5'd9, 32'h0});

    // Bubble: load held in execute while write-back moves on.
    ex_bus   = mk_ex(32'h0000_0300, 1'b1, 1'b1, 5'd6, 32'h0000_0000);
    load_bus = LD_LW;
    ram_sel  = 4'b1111;
    hilo_in  = {1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222};
    stall    = 6'b001111;
    tick();
    rdata = 32'h0BAD_F00D;
    #1;
    check("bubble_wb", wb_bus, 70'h0);
    check("bubble_rf_we", {69'h0, rf_bus[37]}, 70'h0);
    check("bubble_hilo", {4'h0, hilo_out}, 70'h0);
    stall = 6'b000000;
    tick();
    rdata = 32'h0BAD_F00D;
    #1;
    check("after_bubble_wb", wb_bus, {32'h0000_0300, 1'b1, 5'd6, 32'h0BAD_F00D});
    check("after_bubble_hilo", {4'h0, hilo_out}, {4'h0, 1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222});

    // HI/LO capture followed by a three-cycle hold.
    ex_bus   = mk_ex(32'h0000_0400, 1'b0, 1'b1, 5'd8, 32'h0000_0444);
    load_bus = LD_NONE;
    hilo_in  = {1'b1, 1'b0, 32'h1111_1111, 32'h0000_0000};
    tick();
    check("hilo_cap", {4'h0, hilo_out}, {4'h0, 1'b1, 1'b0, 32'h1111_1111, 32'h0});
    ex_bus   = mk_ex(32'h0000_0500, 1'b0, 1'b0, 5'd9, 32'h0000_0555);
    hilo_in  = {1'b0, 1'b1, 32'h0, 32'h9999_9999};
    stall    = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_hilo", {4'h0, hilo_out}, {4'h0, 1'b1, 1'b0, 32'h1111_1111, 32'h0});
      check("hold_wb", wb_bus, {32'h0000_0400, 1'b1, 5'd8, 32'h0000_0444});
    end
    stall = 6'b000000;
    tick();
    check("release_hilo", {4'h0, hilo_out}, {4'h0, 1'b0, 1'b1, 32'h0, 32'h9999_9999});
    check("release_wb", wb_bus, {32'h0000_0500, 1'b0, 5'd9, 32'h0000_0555});

    // Reset mid-stall clears at once; stage restarts empty.
    stall = 6'b011111;
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rst_stall_wb", wb_bus, 70'h0);
    check("rst_stall_hilo", {4'h0, hilo_out}, 70'h0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall_rel", wb_bus, 70'h0);
    tick();
    check("rst_stall_held", wb_bus, 70'h0);
    stall = 6'b000000;
    tick();
    check("rst_stall_cap", wb_bus, {32'h0000_0500, 1'b0, 5'd9, 32'h0000_0555});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
